// File: rtl/mult64_seq_front_pkg.sv
// Shared widths, FSM encoding and partial-product shift table
// for the iterative 64x64 operand-product front end.
package mult64_seq_front_pkg;

    localparam int DATA_W = 64;
    localparam int MU_W   = 31;
    localparam int K_W    = 8;
    localparam int HALF_W = DATA_W / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift applied to each step's partial product: 0, 32, 32, 64.
    function automatic logic [7:0] step_shift(input logic [1:0] step);
        logic [7:0] sh;
        case (step)
            2'd0:    sh = 8'd0;
            2'd1:    sh = 8'(HALF_W);
            2'd2:    sh = 8'(HALF_W);
            default: sh = 8'(DATA_W);
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/vedic_mult32.sv
// Combinational Urdhva-Tiryagbhyam (vertical/crosswise) multiplier.
// Ports: x, y (W bits) operands; p (2W bits) product.
module vedic_mult32 #(
    parameter int W = 32
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);

    logic [7:0] s;
    logic [7:0] carry;
    int         idx;

    // Column c collects every crosswise bit product x[j]*y[c-j]
    // plus the carry from the previous column.
    always_comb begin
        p     = '0;
        s     = '0;
        carry = '0;
        idx   = 0;
        for (int c = 0; c < 2*W-1; c++) begin
            s = carry;
            for (int j = 0; j < W; j++) begin
                idx = c - j;
                if (idx >= 0 && idx < W)
                    s = s + 8'(x[j] & y[idx]);
            end
            p[c]  = s[0];
            carry = s >> 1;
        end
        p[2*W-1] = carry[0];
    end

endmodule

// File: rtl/mult64_seq_front.sv
// Iterative a*b product stage feeding Barrett reduction; q/mu/k ride along.
// Ports: clk, rst; in_valid/in_ready + a,b,q_in,mu_in,k_in; out_valid/out_ready + z,q_out,mu_out,k_out.
module mult64_seq_front
    import mult64_seq_front_pkg::*;
#(
    parameter int DW = mult64_seq_front_pkg::DATA_W,
    parameter int MW = mult64_seq_front_pkg::MU_W,
    parameter int KW = mult64_seq_front_pkg::K_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   q_in,
    input  logic [MW-1:0]   mu_in,
    input  logic [KW-1:0]   k_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] z,
    output logic [DW-1:0]   q_out,
    output logic [MW-1:0]   mu_out,
    output logic [KW-1:0]   k_out
);

    localparam int HW = DW / 2;

    state_t         state, state_nx;
    logic [1:0]     step;
    logic [DW-1:0]  a_r, b_r;
    logic [2*DW-1:0] acc;
    logic [HW-1:0]  op_x, op_y;
    logic [DW-1:0]  pp;
    logic [2*DW-1:0] pp_ext;
    logic           accept;

    // step[0] picks the high half of a, step[1] the high half of b.
    assign op_x   = step[0] ? a_r[DW-1:HW] : a_r[HW-1:0];
    assign op_y   = step[1] ? b_r[DW-1:HW] : b_r[HW-1:0];
    assign pp_ext = {{DW{1'b0}}, pp} << step_shift(step);

    vedic_mult32 #(.W(HW)) u_vm (
        .x (op_x),
        .y (op_y),
        .p (pp)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) state_nx = MUL;
            end
            MUL: begin
                if (step == 2'd3) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            q_out  <= '0;
            mu_out <= '0;
            k_out  <= '0;
        end else if (accept) begin
            step   <= '0;
            a_r    <= a;
            b_r    <= b;
            acc    <= '0;
            q_out  <= q_in;
            mu_out <= mu_in;
            k_out  <= k_in;
        end else if (state == MUL) begin
            step <= step + 2'd1;
            acc  <= acc + pp_ext;
        end
    end

    assign z = acc;

endmodule
